// File: rtl/bsg_mem_1rw_bit_mask_arb_d64_w7.sv
// Zeroes a 64x7 bit-masked single-port SRAM after reset or on request,
// then shares its port between two requesters with round-robin arbitration.
module bsg_mem_1rw_bit_mask_arb_d64_w7 #(
  parameter int unsigned width_p = 7,
  parameter int unsigned els_p   = 64,
  localparam int unsigned addr_width_lp = $clog2(els_p)
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       clear_i,
  output logic                       init_done_o,

  input  logic [1:0]                 req_v_i,
  input  logic [1:0]                 req_w_i,
  input  logic [2*addr_width_lp-1:0] req_addr_i,
  input  logic [2*width_p-1:0]       req_data_i,
  input  logic [2*width_p-1:0]       req_w_mask_i,
  output logic [1:0]                 req_ready_o,

  output logic                       r_v_o,
  output logic                       r_id_o,
  output logic [width_p-1:0]         r_data_o,

  output logic                       mem_v_o,
  output logic                       mem_w_o,
  output logic [addr_width_lp-1:0]   mem_addr_o,
  output logic [width_p-1:0]         mem_data_o,
  output logic [width_p-1:0]         mem_w_mask_o,
  input  logic [width_p-1:0]         mem_data_i
);

  typedef enum logic {
    e_clear = 1'b0,
    e_ready = 1'b1
  } state_e;

  state_e                   state_r, state_n;
  logic [addr_width_lp-1:0] clr_cnt_r, clr_cnt_n;
  logic                     last_r, last_n;
  logic                     r_v_r, r_v_n;
  logic                     r_id_r, r_id_n;

  logic                     gnt_v;
  logic                     gnt_id;

  // Both valid: pick the one not served last; otherwise the lone valid one.
  always_comb begin
    gnt_id = 1'b0;
    if (req_v_i == 2'b11) gnt_id = ~last_r;
    else                  gnt_id = req_v_i[1];
    gnt_v = (state_r == e_ready) && (req_v_i != 2'b00);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r   <= e_clear;
      clr_cnt_r <= '0;
      last_r    <= 1'b1;
      r_v_r     <= 1'b0;
      r_id_r    <= 1'b0;
    end else begin
      state_r   <= state_n;
      clr_cnt_r <= clr_cnt_n;
      last_r    <= last_n;
      r_v_r     <= r_v_n;
      r_id_r    <= r_id_n;
    end
  end

  always_comb begin
    state_n      = state_r;
    clr_cnt_n    = clr_cnt_r;
    last_n       = last_r;
    r_v_n        = 1'b0;
    r_id_n       = r_id_r;
    req_ready_o  = 2'b00;
    mem_v_o      = 1'b0;
    mem_w_o      = 1'b0;
    mem_addr_o   = '0;
    mem_data_o   = '0;
    mem_w_mask_o = '0;

    unique case (state_r)
      e_clear: begin
        // mem_v_o is held low while reset is asserted so nothing is written.
        mem_v_o      = ~reset_i;
        mem_w_o      = 1'b1;
        mem_addr_o   = clr_cnt_r;
        mem_w_mask_o = '1;
        clr_cnt_n    = clr_cnt_r + addr_width_lp'(1);
        if (clr_cnt_r == addr_width_lp'(els_p - 1)) begin
          state_n = e_ready;
        end
      end
      e_ready: begin
        if (clear_i) state_n = e_clear;
        if (gnt_v) begin
          req_ready_o[gnt_id] = 1'b1;
          last_n              = gnt_id;
          mem_v_o             = 1'b1;
          mem_w_o             = req_w_i[gnt_id];
          mem_addr_o   = gnt_id ? req_addr_i[2*addr_width_lp-1:addr_width_lp]
                                : req_addr_i[addr_width_lp-1:0];
          mem_data_o   = gnt_id ? req_data_i[2*width_p-1:width_p]
                                : req_data_i[width_p-1:0];
          mem_w_mask_o = gnt_id ? req_w_mask_i[2*width_p-1:width_p]
                                : req_w_mask_i[width_p-1:0];
          if (!req_w_i[gnt_id]) begin
            r_v_n  = 1'b1;
            r_id_n = gnt_id;
          end
        end
      end
      default: state_n = e_clear;
    endcase
  end

  assign init_done_o = (state_r == e_ready);
  assign r_v_o       = r_v_r;
  assign r_id_o      = r_id_r;
  assign r_data_o    = mem_data_i;

endmodule

// File: tb/tb_bsg_mem_1rw_bit_mask_arb_d64_w7.sv
// Directed bench: drives the scheduler against a bit-masked 64x7 SRAM model
// and compares every observation with hand-computed values.
module tb_bsg_mem_1rw_bit_mask_arb_d64_w7;

  logic        clk;
  logic        reset;
  logic        clear;
  logic        init_done;
  logic [1:0]  req_v;
  logic [1:0]  req_w;
  logic [11:0] req_addr;
  logic [13:0] req_data;
  logic [13:0] req_mask;
  logic [1:0]  req_ready;
  logic        r_v;
  logic        r_id;
  logic [6:0]  r_data;
  logic        mem_v;
  logic        mem_w;
  logic [5:0]  mem_addr;
  logic [6:0]  mem_wdata;
  logic [6:0]  mem_mask;
  logic [6:0]  mem_rdata;

  logic [6:0]  mem [64];

  int n_cmp = 0;
  int n_err = 0;

  bsg_mem_1rw_bit_mask_arb_d64_w7 dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .clear_i      (clear),
    .init_done_o  (init_done),
    .req_v_i      (req_v),
    .req_w_i      (req_w),
    .req_addr_i   (req_addr),
    .req_data_i   (req_data),
    .req_w_mask_i (req_mask),
    .req_ready_o  (req_ready),
    .r_v_o        (r_v),
    .r_id_o       (r_id),
    .r_data_o     (r_data),
    .mem_v_o      (mem_v),
    .mem_w_o      (mem_w),
    .mem_addr_o   (mem_addr),
    .mem_data_o   (mem_wdata),
    .mem_w_mask_o (mem_mask),
    .mem_data_i   (mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Bit-masked SRAM: read data appears next cycle and holds until the next read.
  always @(posedge clk) begin
    if (mem_v) begin
      if (mem_w) mem[mem_addr] <= (mem[mem_addr] & ~mem_mask) | (mem_wdata & mem_mask);
      else       mem_rdata     <= mem[mem_addr];
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req_v = 2'b00;
    req_w = 2'b00;
  endtask

  task automatic put(input int k, input logic w, input logic [5:0] a,
                     input logic [6:0] d, input logic [6:0] m);
    req_v[k]           = 1'b1;
    req_w[k]           = w;
    req_addr[k*6 +: 6] = a;
    req_data[k*7 +: 7] = d;
    req_mask[k*7 +: 7] = m;
  endtask

  task automatic check_resp(input string tag, input logic id, input logic [6:0] d);
    check_eq(tag, 32'({r_v, r_id, r_data}), 32'({1'b1, id, d}));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [6:0] acc;
    reset    = 1'b1;
    clear    = 1'b0;
    req_v    = 2'b00;
    req_w    = 2'b00;
    req_addr = '0;
    req_data = '0;
    req_mask = '0;
    for (int i = 0; i < 64; i++) mem[i] = 7'h7F;
    mem_rdata = 7'h7F;

    // Reset state with both requesters valid
    put(0, 1'b0, 6'd7, 7'h0, 7'h0);
    put(1, 1'b0, 6'd8, 7'h0, 7'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_outputs", 32'({init_done, req_ready, r_v, r_id, mem_v}), 32'(0));
    next_cycle();
    reset = 1'b0;

    // Initial clear: 64 full-mask zero writes, requests held off
    for (int i = 0; i < 64; i++) begin
      clear = (i >= 10 && i < 20);
      @(negedge clk);
      check_eq("clr_addr", 32'(mem_addr), 32'(i));
      check_eq("clr_ctrl", 32'({mem_v, mem_w, mem_wdata, mem_mask}), 32'({1'b1, 1'b1, 7'h00, 7'h7F}));
      check_eq("clr_ready", 32'({init_done, req_ready}), 32'(0));
      next_cycle();
    end
    clear = 1'b0;

    // Cycle 64: READY, read addr 63
    idle();
    put(0, 1'b0, 6'd63, 7'h0, 7'h0);
    @(negedge clk);
    check_eq("init_done", 32'(init_done), 32'(1));
    check_eq("rd63_grant", 32'({req_ready, mem_v, mem_w, mem_addr}), 32'({2'b01, 1'b1, 1'b0, 6'd63}));
    next_cycle();

    acc = '0;
    for (int i = 0; i < 64; i++) acc = acc | mem[i];
    check_eq("array_zeroed", 32'(acc), 32'(0));

    // Masked write by requester 0, then read by requester 1
    idle();
    put(0, 1'b1, 6'd5, 7'h55, 7'h0F);
    @(negedge clk);
    check_resp("rd63_resp", 1'b0, 7'h00);
    check_eq("mwr_grant", 32'({req_ready, mem_w, mem_addr, mem_wdata, mem_mask}),
             32'({2'b01, 1'b1, 6'd5, 7'h55, 7'h0F}));
    next_cycle();
    idle();
    put(1, 1'b0, 6'd5, 7'h0, 7'h0);
    @(negedge clk);
    check_eq("mwr_no_resp", 32'(r_v), 32'(0));
    check_eq("rd5_grant", 32'(req_ready), 32'(2'b10));
    next_cycle();
    idle();
    @(negedge clk);
    check_resp("rd5_resp", 1'b1, 7'h05);
    check_eq("idle_mem_off", 32'({req_ready, mem_v, mem_w, mem_addr, mem_wdata, mem_mask}), 32'(0));
    next_cycle();

    // Round-robin setup: requester 1 writes addrs 1 and 2
    idle();
    put(1, 1'b1, 6'd1, 7'h21, 7'h7F);
    next_cycle();
    idle();
    put(1, 1'b1, 6'd2, 7'h42, 7'h7F);
    next_cycle();

    // Both requesters reading continuously
    idle();
    put(0, 1'b0, 6'd1, 7'h0, 7'h0);
    put(1, 1'b0, 6'd2, 7'h0, 7'h0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check_eq("rr_grant", 32'(req_ready), (c % 2 == 0) ? 32'(2'b01) : 32'(2'b10));
      if (c > 0) begin
        if (c % 2 == 1) check_resp("rr_resp0", 1'b0, 7'h21);
        else            check_resp("rr_resp1", 1'b1, 7'h42);
      end
      next_cycle();
    end
    idle();
    @(negedge clk);
    check_resp("rr_resp_last", 1'b1, 7'h42);
    next_cycle();

    // Read then write same address on consecutive cycles
    put(0, 1'b1, 6'd9, 7'h11, 7'h7F);
    next_cycle();
    idle();
    put(0, 1'b0, 6'd9, 7'h0, 7'h0);
    next_cycle();
    idle();
    put(1, 1'b1, 6'd9, 7'h22, 7'h7F);
    @(negedge clk);
    check_resp("raw_old", 1'b0, 7'h11);
    next_cycle();
    idle();
    put(0, 1'b0, 6'd9, 7'h0, 7'h0);
    @(negedge clk);
    check_eq("raw_wr_no_resp", 32'(r_v), 32'(0));
    next_cycle();
    idle();
    @(negedge clk);
    check_resp("raw_new", 1'b0, 7'h22);
    next_cycle();

    // Re-clear issued alongside a read
    put(0, 1'b1, 6'd3, 7'h3C, 7'h7F);
    next_cycle();
    idle();
    put(0, 1'b0, 6'd3, 7'h0, 7'h0);
    clear = 1'b1;
    @(negedge clk);
    check_eq("reclr_rd_grant", 32'({init_done, req_ready}), 32'({1'b1, 2'b01}));
    next_cycle();
    clear = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (i == 0) check_resp("reclr_preclear_resp", 1'b0, 7'h3C);
      check_eq("reclr_ready", 32'({init_done, req_ready}), 32'(0));
      check_eq("reclr_addr", 32'({mem_v, mem_addr}), 32'({1'b1, 6'(i)}));
      next_cycle();
    end
    idle();
    put(1, 1'b0, 6'd3, 7'h0, 7'h0);
    @(negedge clk);
    check_eq("reclr_done", 32'({init_done, req_ready}), 32'({1'b1, 2'b10}));
    next_cycle();
    idle();
    @(negedge clk);
    check_resp("reclr_rd3", 1'b1, 7'h00);
    next_cycle();

    // Reset asserted mid-clear at clear cycle 30
    clear = 1'b1;
    next_cycle();
    clear = 1'b0;
    for (int i = 0; i < 30; i++) next_cycle();
    @(negedge clk);
    check_eq("midclr_addr30", 32'({mem_v, mem_addr}), 32'({1'b1, 6'd30}));
    #1 reset = 1'b1;
    #1;
    check_eq("midclr_rst_outputs", 32'({init_done, req_ready, r_v, r_id, mem_v}), 32'(0));
    next_cycle();
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    check_eq("restart_addr0", 32'({mem_v, mem_addr}), 32'({1'b1, 6'd0}));
    next_cycle();
    @(negedge clk);
    check_eq("restart_addr1", 32'({mem_v, mem_addr}), 32'({1'b1, 6'd1}));
    for (int i = 0; i < 63; i++) next_cycle();

    // Reset right after a read grant drops the response
    put(0, 1'b0, 6'd5, 7'h0, 7'h0);
    @(negedge clk);
    check_eq("drop_grant", 32'({init_done, req_ready}), 32'({1'b1, 2'b01}));
    #1 reset = 1'b1;
    next_cycle();
    @(negedge clk);
    check_eq("drop_resp", 32'({r_v, mem_v, init_done}), 32'(0));
    idle();
    reset = 1'b0;
    next_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
